div_arbiter: RTL and testbench

- Shares one iterative 8-bit restoring divider among THREADS per-thread requesters, so each thread ALU does not need its own combinational divider.
- Thread ALUs issue a divide request while in CORE_EXECUTE. A round-robin arbiter grants one requester, runs a fixed-latency divide, and returns quotient and remainder with a one-hot done pulse.
- Sits inside a core, between the per-thread ALUs and the single shared divide datapath.

---
 rtl/div_if.sv | 25 ++
 rtl/div_arbiter.sv | 145 ++++++++++++++
 tb/tb_div_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake bundle between the per-thread divide requesters and the shared divider.
// Requesters drive the master side; the arbiter sits on the slave side.
interface div_if #(
    parameter int THREADS = 4,
    parameter int WIDTH   = 8
);
    logic [THREADS-1:0]       req;
    logic [THREADS*WIDTH-1:0] dividend;
    logic [THREADS*WIDTH-1:0] divisor;
    logic [THREADS-1:0]       grant;
    logic                     busy;
    logic [THREADS-1:0]       done;
    logic [WIDTH-1:0]         quotient;
    logic [WIDTH-1:0]         remainder;

    modport master (
        output req, dividend, divisor,
        input  grant, busy, done, quotient, remainder
    );

    modport slave (
        input  req, dividend, divisor,
        output grant, busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative restoring divider among THREADS requesters.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes straight from LOAD.
module div_arbiter #(
    parameter int THREADS = 4,
    parameter int WIDTH   = 8
) (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);
    localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, DONE} state_t;

    state_t             state_reg;
    logic [THREADS-1:0] grant_reg;
    logic [THREADS-1:0] done_reg;
    logic               busy_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   dsr_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [WIDTH-1:0] dvd_arr [THREADS];
    logic [WIDTH-1:0] dsr_arr [THREADS];

    generate
        for (genvar gi = 0; gi < THREADS; gi++) begin : g_unpack
            assign dvd_arr[gi] = bus.dividend[gi*WIDTH +: WIDTH];
            assign dsr_arr[gi] = bus.divisor[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester at or after rr_ptr wins.
    logic [IDX_W-1:0] sel_idx_next;
    logic [IDX_W-1:0] scan_idx;
    int               scan_pos;

    always_comb begin
        sel_idx_next = '0;
        scan_idx     = '0;
        scan_pos     = 0;
        for (int k = THREADS - 1; k >= 0; k--) begin
            scan_pos = int'(rr_ptr_reg) + k;
            if (scan_pos >= THREADS) begin
                scan_pos = scan_pos - THREADS;
            end
            scan_idx = IDX_W'(scan_pos);
            if (bus.req[scan_idx]) begin
                sel_idx_next = scan_idx;
            end
        end
    end

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits before the compare.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   dsr_ext;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        shifted  = {rem_reg, q_reg[WIDTH-1]};
        dsr_ext  = {1'b0, dsr_reg};
        ge       = (shifted >= dsr_ext);
        rem_step = ge ? WIDTH'(shifted - dsr_ext) : shifted[WIDTH-1:0];
        q_step   = {q_reg[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            done_reg      <= '0;
            busy_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            rr_ptr_reg    <= '0;
            idx_reg       <= '0;
            q_reg         <= '0;
            dsr_reg       <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        grant_reg <= THREADS'(1) << sel_idx_next;
                        idx_reg   <= sel_idx_next;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    q_reg   <= dvd_arr[idx_reg];
                    dsr_reg <= dsr_arr[idx_reg];
                    rem_reg <= '0;
                    cnt_reg <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
                    if (dsr_arr[idx_reg] == '0) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dvd_arr[idx_reg];
                        done_reg      <= grant_reg;
                        state_reg     <= DONE;
                    end else begin
                        state_reg <= DIVIDE;
                    end
`else
                    state_reg <= DIVIDE;
`endif
                end
                DIVIDE: begin
                    rem_reg <= rem_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        quotient_reg  <= q_step;
                        remainder_reg <= rem_step;
                        done_reg      <= grant_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    grant_reg  <= '0;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= (idx_reg == IDX_W'(THREADS - 1)) ? '0 : idx_reg + 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: directed scenarios plus randomized multi-thread traffic.
module tb_div_arbiter;
    localparam int T = 4;
    localparam int W = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_if #(.THREADS(T), .WIDTH(W)) bus ();
    div_arbiter #(.THREADS(T), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [T][$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return {8'hFF, a};
        return {8'(a / b), 8'(a % b)};
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation of that thread.
    always @(negedge clk) begin
        int t;
        logic [15:0] e;
        if (!reset && bus.done != '0) begin
            t = 0;
            for (int i = 0; i < T; i++) if (bus.done[i]) t = i;
            check("done_onehot", $countones(bus.done), 1);
            check("grant_matches_done", bus.grant, bus.done);
            if (exp_q[t].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: thread %0d q=%0d r=%0d, no request outstanding",
                         t, bus.quotient, bus.remainder);
            end else begin
                e = exp_q[t].pop_front();
                check("quotient", bus.quotient, e[15:8]);
                check("remainder", bus.remainder, e[7:0]);
                $display("[TB] t%0d done q=%0d r=%0d (expected %0d r%0d)",
                         t, bus.quotient, bus.remainder, e[15:8], e[7:0]);
            end
        end
    end

    task automatic issue(input int t, input logic [7:0] a, input logic [7:0] b);
        bus.dividend[t*W +: W] = a;
        bus.divisor[t*W +: W]  = b;
        bus.req[t]             = 1'b1;
        exp_q[t].push_back(ref_div(a, b));
    endtask

    task automatic wait_done(input int max, output int thr, output int lat, output int bsy);
        thr = -1;
        lat = 0;
        bsy = 0;
        while (thr < 0 && lat < max) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bsy++;
            if (bus.done != '0) begin
                for (int i = 0; i < T; i++) if (bus.done[i]) thr = i;
                bus.req = bus.req & ~bus.done;
            end
        end
        if (thr < 0) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: no done within %0d cycles", max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int thr, lat, bsy, total;
        int order [5];
        logic [T-1:0] snap;
        logic [7:0] a, b;
        order = '{0, 1, 2, 3, 0};

        reset        = 1'b1;
        bus.req      = '0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_grant", bus.grant, 0);
        check("reset_done", bus.done, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);

        // Single request with exact latency and busy window
        issue(0, 8'd100, 8'd7);
        wait_done(30, thr, lat, bsy);
        check("single_thread", thr, 0);
        check("single_latency", lat, 10);
        check("single_busy_cycles", bsy, 10);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_grant", bus.grant, 0);
        check("hold_quotient", bus.quotient, 14);
        check("hold_remainder", bus.remainder, 2);

        // Full operand range
        issue(2, 8'd255, 8'd1);
        wait_done(30, thr, lat, bsy);
        check("max_dividend_latency", lat, 10);
        @(negedge clk);
        issue(2, 8'd3, 8'd200);
        wait_done(30, thr, lat, bsy);
        check("small_dividend_thread", thr, 2);
        @(negedge clk);

        // Divide by zero
        issue(1, 8'd42, 8'd0);
        wait_done(30, thr, lat, bsy);
        check("div0_thread", thr, 1);
        check("div0_latency", lat, ZLAT);
        @(negedge clk);

        // Operand change after LOAD is ignored
        issue(0, 8'd100, 8'd7);
        repeat (2) @(negedge clk);
        bus.dividend[7:0] = 8'd9;
        bus.divisor[7:0]  = 8'd2;
        wait_done(30, thr, lat, bsy);
        check("late_change_latency", lat, 8);
        @(negedge clk);

        // Round robin from a fresh pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 8'd50, 8'd5);
        issue(1, 8'd81, 8'd9);
        issue(2, 8'd17, 8'd4);
        issue(3, 8'd200, 8'd13);
        for (int n = 0; n < 5; n++) begin
            wait_done(40, thr, lat, bsy);
            check("rr_order", thr, order[n]);
            if (n == 0) begin
                check("rr_first_latency", lat, 10);
                @(negedge clk);
                issue(0, 8'd123, 8'd11);
            end else if (n == 1) begin
                check("rr_spacing", lat + 1, 11);
            end else begin
                check("rr_spacing", lat, 11);
            end
        end
        @(negedge clk);

        // Reset mid-operation: pointer was 1, t3 in flight
        bus.dividend[3*W +: W] = 8'd10;
        bus.divisor[3*W +: W]  = 8'd3;
        bus.req[3] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_grant", bus.grant, 0);
        check("midreset_done", bus.done, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_quotient", bus.quotient, 0);
        check("midreset_remainder", bus.remainder, 0);
        reset   = 1'b0;
        bus.req = '0;
        issue(0, 8'd77, 8'd7);
        issue(2, 8'd66, 8'd6);
        wait_done(30, thr, lat, bsy);
        check("midreset_rr_ptr_zero", thr, 0);
        check("midreset_latency", lat, 10);
        wait_done(30, thr, lat, bsy);
        check("midreset_second", thr, 2);
        @(negedge clk);
        issue(3, 8'd200, 8'd13);
        wait_done(30, thr, lat, bsy);
        check("t3_after_reset", thr, 3);
        check("t3_after_reset_latency", lat, 10);
        @(negedge clk);

        // Randomized traffic on all threads
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            snap    = bus.req;
            bus.req = bus.req & ~bus.done;
            if (cyc < 300) begin
                for (int i = 0; i < T; i++) begin
                    if (!snap[i] && $urandom_range(3) == 0) begin
                        a = 8'($urandom_range(255));
                        b = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255));
                        issue(i, a, b);
                    end
                end
            end
        end
        for (int cyc = 0; cyc < 200 && bus.req != '0; cyc++) begin
            @(negedge clk);
            bus.req = bus.req & ~bus.done;
        end
        repeat (3) @(negedge clk);
        check("random_drained", bus.req, 0);
        total = 0;
        for (int i = 0; i < T; i++) total += exp_q[i].size();
        check("scoreboard_empty", total, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
